// File: rtl/sram_arbiter.sv
// ============================================================================
// sram_arbiter : round-robin two-port arbiter and access sequencer for an
//                asynchronous 16-bit SRAM (active-low controls, shared DQ).
// Revision     : 1.0
// ============================================================================
`default_nettype none

module sram_arbiter #(
   parameter int unsigned WaitCycles = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req0,
   input  logic        Req1,
   input  logic        Wr0,
   input  logic        Wr1,
   input  logic [19:0] Addr0,
   input  logic [19:0] Addr1,
   input  logic [15:0] WData0,
   input  logic [15:0] WData1,
   input  logic [1:0]  BE0,
   input  logic [1:0]  BE1,
   output logic        Ack0,
   output logic        Ack1,
   output logic [15:0] RData0,
   output logic [15:0] RData1,
   output logic        Busy,
   output logic        CE,
   output logic        OE,
   output logic        WE,
   output logic        LB,
   output logic        UB,
   output logic [19:0] ADDR,
   inout  wire  [15:0] DQ
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [3:0] CNT_INIT  = 4'(WaitCycles);

   logic [1:0]  state_q, state_d;
   logic        last_q, last_d;
   logic        grant_q, grant_d;
   logic        wr_q, wr_d;
   logic [19:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [1:0]  be_q, be_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] rdata0_q, rdata0_d;
   logic [15:0] rdata1_q, rdata1_d;

   logic        sel;
   logic [15:0] capture;
   logic        dq_oe;

   // On a tie the port that was not served last wins.
   assign sel     = (Req0 && Req1) ? ~last_q : Req1;
   assign capture = {be_q[1] ? DQ[15:8] : 8'h00, be_q[0] ? DQ[7:0] : 8'h00};

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         last_q   <= 1'b1;
         grant_q  <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         cnt_q    <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         cnt_q    <= cnt_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      grant_d  = grant_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      cnt_d    = cnt_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         ST_IDLE: begin
            if (Req0 || Req1) begin
               grant_d = sel;
               last_d  = sel;
               wr_d    = sel ? Wr1    : Wr0;
               addr_d  = sel ? Addr1  : Addr0;
               wdata_d = sel ? WData1 : WData0;
               be_d    = sel ? BE1    : BE0;
               cnt_d   = CNT_INIT;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
               if (!wr_q) begin
                  if (grant_q) rdata1_d = capture;
                  else         rdata0_d = capture;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      CE    = 1'b1;
      OE    = 1'b1;
      WE    = 1'b1;
      LB    = 1'b1;
      UB    = 1'b1;
      ADDR  = '0;
      dq_oe = 1'b0;
      Ack0  = 1'b0;
      Ack1  = 1'b0;
      case (state_q)
         ST_ACCESS: begin
            CE    = 1'b0;
            ADDR  = addr_q;
            UB    = ~be_q[1];
            LB    = ~be_q[0];
            OE    = wr_q;
            WE    = ~wr_q;
            dq_oe = wr_q;
         end
         ST_DONE: begin
            Ack0 = ~grant_q;
            Ack1 = grant_q;
         end
         default: ;
      endcase
   end

   assign Busy   = (state_q != ST_IDLE);
   assign RData0 = rdata0_q;
   assign RData1 = rdata1_q;
   assign DQ     = dq_oe ? wdata_q : 16'hzzzz;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// tb_sram_arbiter : directed bench for sram_arbiter with a behavioural SRAM.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Req0 = 1'b0, Req1 = 1'b0, Wr0 = 1'b0, Wr1 = 1'b0;
   logic [19:0] Addr0 = '0, Addr1 = '0;
   logic [15:0] WData0 = '0, WData1 = '0;
   logic [1:0]  BE0 = '0, BE1 = '0;
   logic        Ack0, Ack1, Busy, CE, OE, WE, LB, UB;
   logic [15:0] RData0, RData1;
   logic [19:0] ADDR;
   wire  [15:0] DQ;

   logic        sa_req = 1'b0, sb_req = 1'b0;
   logic        sa_ack0, sa_ack1, sa_busy, sa_ce, sa_oe, sa_we, sa_lb, sa_ub;
   logic        sb_ack0, sb_ack1, sb_busy, sb_ce, sb_oe, sb_we, sb_lb, sb_ub;
   logic [15:0] sa_rd0, sa_rd1, sb_rd0, sb_rd1;
   logic [19:0] sa_addr, sb_addr;
   wire  [15:0] sa_dq, sb_dq;

   int n_pass = 0;
   int n_total = 0;

   always #5 Clk = ~Clk;

   sram_arbiter #(.WaitCycles(1)) dut (
      .Clk(Clk), .Reset(Reset),
      .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
      .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
      .BE0(BE0), .BE1(BE1), .Ack0(Ack0), .Ack1(Ack1),
      .RData0(RData0), .RData1(RData1), .Busy(Busy),
      .CE(CE), .OE(OE), .WE(WE), .LB(LB), .UB(UB), .ADDR(ADDR), .DQ(DQ)
   );

   sram_arbiter #(.WaitCycles(0)) dut_w0 (
      .Clk(Clk), .Reset(Reset),
      .Req0(sa_req), .Req1(1'b0), .Wr0(1'b0), .Wr1(1'b0),
      .Addr0(20'h00003), .Addr1(20'h0), .WData0(16'h0), .WData1(16'h0),
      .BE0(2'b11), .BE1(2'b00), .Ack0(sa_ack0), .Ack1(sa_ack1),
      .RData0(sa_rd0), .RData1(sa_rd1), .Busy(sa_busy),
      .CE(sa_ce), .OE(sa_oe), .WE(sa_we), .LB(sa_lb), .UB(sa_ub), .ADDR(sa_addr), .DQ(sa_dq)
   );

   sram_arbiter #(.WaitCycles(3)) dut_w3 (
      .Clk(Clk), .Reset(Reset),
      .Req0(sb_req), .Req1(1'b0), .Wr0(1'b0), .Wr1(1'b0),
      .Addr0(20'h00003), .Addr1(20'h0), .WData0(16'h0), .WData1(16'h0),
      .BE0(2'b01), .BE1(2'b00), .Ack0(sb_ack0), .Ack1(sb_ack1),
      .RData0(sb_rd0), .RData1(sb_rd1), .Busy(sb_busy),
      .CE(sb_ce), .OE(sb_oe), .WE(sb_we), .LB(sb_lb), .UB(sb_ub), .ADDR(sb_addr), .DQ(sb_dq)
   );

   // Behavioural SRAM: drives DQ on a read, latches enabled lanes on a write.
   logic [15:0] mem [0:63] = '{1: 16'h102F, default: 16'h0000};
   assign DQ    = (!CE && !OE && WE) ? mem[ADDR[5:0]] : 16'hzzzz;
   assign sa_dq = (!sa_ce && !sa_oe) ? 16'hA5C3 : 16'hzzzz;
   assign sb_dq = (!sb_ce && !sb_oe) ? 16'hA5C3 : 16'hzzzz;

   always @(posedge Clk) begin
      if (!CE && !WE) begin
         if (!LB) mem[ADDR[5:0]][7:0]  <= DQ[7:0];
         if (!UB) mem[ADDR[5:0]][15:8] <= DQ[15:8];
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic run_access(input bit port, input bit wr, input logic [19:0] a,
                             input logic [15:0] wd, input logic [1:0] be,
                             output int lat, output int acc, output int we_cyc,
                             output logic [15:0] dq_w, output logic [1:0] ublb);
      for (int i = 0; i < 8 && Busy; i++) tick();
      if (port) begin Req1 = 1'b1; Wr1 = wr; Addr1 = a; WData1 = wd; BE1 = be; end
      else      begin Req0 = 1'b1; Wr0 = wr; Addr0 = a; WData0 = wd; BE0 = be; end
      lat = -1; acc = 0; we_cyc = 0; dq_w = 16'hxxxx; ublb = 2'bxx;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (!CE) begin acc++; ublb = {UB, LB}; end
         if (!WE) begin we_cyc++; dq_w = DQ; end
         if (port ? Ack1 : Ack0) begin lat = i; break; end
      end
      Req0 = 1'b0;
      Req1 = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick(); tick();
      if ({CE, OE, WE, LB, UB} !== 5'b11111) $display("FAIL reset_ctrl: got %b expected 11111", {CE, OE, WE, LB, UB});
      else n_pass++;
      n_total++;
      if (ADDR !== 20'h0) $display("FAIL reset_addr: got %h expected 00000", ADDR);
      else n_pass++;
      n_total++;
      if ({Ack0, Ack1, Busy} !== 3'b000) $display("FAIL reset_ack_busy: got %b expected 000", {Ack0, Ack1, Busy});
      else n_pass++;
      n_total++;
      if (RData0 !== 16'h0) $display("FAIL reset_rdata0: got %h expected 0000", RData0);
      else n_pass++;
      n_total++;
      if (RData1 !== 16'h0) $display("FAIL reset_rdata1: got %h expected 0000", RData1);
      else n_pass++;
      n_total++;
      Reset = 1'b0;
   endtask

   task automatic test_single_read();
      int lat, acc, wec;
      logic [15:0] dqw;
      logic [1:0]  ublb;
      run_access(1'b0, 1'b0, 20'h00001, 16'h0, 2'b11, lat, acc, wec, dqw, ublb);
      if (lat !== 3) $display("FAIL read_latency: got %0d expected 3", lat);
      else n_pass++;
      n_total++;
      if (acc !== 2) $display("FAIL read_access_len: got %0d expected 2", acc);
      else n_pass++;
      n_total++;
      if (wec !== 0) $display("FAIL read_we_low: got %0d expected 0", wec);
      else n_pass++;
      n_total++;
      if (RData0 !== 16'h102F) $display("FAIL read_rdata0: got %h expected 102f", RData0);
      else n_pass++;
      n_total++;
   endtask

   task automatic test_write_readback();
      int lat, acc, wec;
      logic [15:0] dqw;
      logic [1:0]  ublb;
      run_access(1'b1, 1'b1, 20'h00005, 16'hBEEF, 2'b11, lat, acc, wec, dqw, ublb);
      if (lat !== 3) $display("FAIL write_latency: got %0d expected 3", lat);
      else n_pass++;
      n_total++;
      if (wec !== 2) $display("FAIL write_we_len: got %0d expected 2", wec);
      else n_pass++;
      n_total++;
      if (dqw !== 16'hBEEF) $display("FAIL write_dq: got %h expected beef", dqw);
      else n_pass++;
      n_total++;
      run_access(1'b1, 1'b0, 20'h00005, 16'h0, 2'b11, lat, acc, wec, dqw, ublb);
      if (lat !== 3) $display("FAIL readback_latency: got %0d expected 3", lat);
      else n_pass++;
      n_total++;
      if (RData1 !== 16'hBEEF) $display("FAIL readback_rdata1: got %h expected beef", RData1);
      else n_pass++;
      n_total++;
   endtask

   task automatic test_byte_enable();
      int lat, acc, wec;
      logic [15:0] dqw;
      logic [1:0]  ublb;
      run_access(1'b0, 1'b1, 20'h00005, 16'h1234, 2'b01, lat, acc, wec, dqw, ublb);
      if (ublb !== 2'b10) $display("FAIL be01_write_ublb: got %b expected 10", ublb);
      else n_pass++;
      n_total++;
      run_access(1'b0, 1'b0, 20'h00005, 16'h0, 2'b11, lat, acc, wec, dqw, ublb);
      if (RData0 !== 16'hBE34) $display("FAIL be_merge_read: got %h expected be34", RData0);
      else n_pass++;
      n_total++;
      run_access(1'b0, 1'b0, 20'h00005, 16'h0, 2'b10, lat, acc, wec, dqw, ublb);
      if (RData0 !== 16'hBE00) $display("FAIL be10_read: got %h expected be00", RData0);
      else n_pass++;
      n_total++;
      if (ublb !== 2'b01) $display("FAIL be10_ublb: got %b expected 01", ublb);
      else n_pass++;
      n_total++;
      run_access(1'b0, 1'b0, 20'h00005, 16'h0, 2'b00, lat, acc, wec, dqw, ublb);
      if (RData0 !== 16'h0000) $display("FAIL be00_read: got %h expected 0000", RData0);
      else n_pass++;
      n_total++;
      if (ublb !== 2'b11) $display("FAIL be00_ublb: got %b expected 11", ublb);
      else n_pass++;
      n_total++;
      if (lat !== 3) $display("FAIL be00_latency: got %0d expected 3", lat);
      else n_pass++;
      n_total++;
      if (RData1 !== 16'hBEEF) $display("FAIL rdata1_held: got %h expected beef", RData1);
      else n_pass++;
      n_total++;
   endtask

   task automatic test_contention();
      int n_ack = 0, wide = 0, both = 0, low = 0, badgap = 0, gaps = 0;
      logic prev_ack = 1'b0;
      logic [3:0] ord = 4'b0000;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      Req0 = 1'b1; Wr0 = 1'b0; Addr0 = 20'h00001; BE0 = 2'b11;
      Req1 = 1'b1; Wr1 = 1'b0; Addr1 = 20'h00005; BE1 = 2'b11;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (Ack0 && Ack1) both++;
         if (Ack0 || Ack1) begin
            if (prev_ack) wide++;
            if (n_ack < 4) ord[n_ack] = Ack1;
            n_ack++;
         end
         prev_ack = Ack0 || Ack1;
         if (!Busy) low++;
         else begin
            if (low > 0 && n_ack > 0) begin
               gaps++;
               if (low != 1) badgap++;
            end
            low = 0;
         end
      end
      Req0 = 1'b0;
      Req1 = 1'b0;
      if (n_ack < 4) $display("FAIL contention_ack_count: got %0d expected >=4", n_ack);
      else n_pass++;
      n_total++;
      if (ord !== 4'b1010) $display("FAIL contention_order: got %b expected 1010 (lsb first)", ord);
      else n_pass++;
      n_total++;
      if (wide !== 0 || both !== 0) $display("FAIL contention_ack_width: got wide=%0d both=%0d expected 0 0", wide, both);
      else n_pass++;
      n_total++;
      if (badgap !== 0 || gaps < 3) $display("FAIL contention_busy_gap: got bad=%0d gaps=%0d expected 0 and >=3", badgap, gaps);
      else n_pass++;
      n_total++;
      if (RData0 !== 16'h102F) $display("FAIL contention_rdata0: got %h expected 102f", RData0);
      else n_pass++;
      n_total++;
      if (RData1 !== 16'hBE34) $display("FAIL contention_rdata1: got %h expected be34", RData1);
      else n_pass++;
      n_total++;
      for (int i = 0; i < 8 && Busy; i++) tick();
   endtask

   task automatic test_reset_mid_write();
      logic [1:0] first = 2'b00;
      for (int i = 0; i < 8 && Busy; i++) tick();
      Req0 = 1'b1; Wr0 = 1'b1; Addr0 = 20'h00009; WData0 = 16'h7777; BE0 = 2'b11;
      tick();
      if ({CE, WE} !== 2'b00) $display("FAIL midwrite_active: got %b expected 00", {CE, WE});
      else n_pass++;
      n_total++;
      Req1 = 1'b1; Wr1 = 1'b0; Addr1 = 20'h00001; BE1 = 2'b11;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      if ({CE, WE, OE, Ack0, Ack1, Busy} !== 6'b111000) $display("FAIL midwrite_reset_outputs: got %b expected 111000", {CE, WE, OE, Ack0, Ack1, Busy});
      else n_pass++;
      n_total++;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (Ack0 || Ack1) begin first = {Ack1, Ack0}; break; end
      end
      Req0 = 1'b0;
      Req1 = 1'b0;
      if (first !== 2'b01) $display("FAIL post_reset_tie: got %b expected 01", first);
      else n_pass++;
      n_total++;
      for (int i = 0; i < 8 && Busy; i++) tick();
   endtask

   task automatic test_param_sweep();
      int lat = -1, acc = 0;
      sa_req = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (!sa_ce) acc++;
         if (sa_ack0) begin lat = i; break; end
      end
      sa_req = 1'b0;
      if (lat !== 2) $display("FAIL w0_latency: got %0d expected 2", lat);
      else n_pass++;
      n_total++;
      if (acc !== 1) $display("FAIL w0_access_len: got %0d expected 1", acc);
      else n_pass++;
      n_total++;
      if (sa_rd0 !== 16'hA5C3) $display("FAIL w0_rdata: got %h expected a5c3", sa_rd0);
      else n_pass++;
      n_total++;
      lat = -1; acc = 0;
      sb_req = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (!sb_ce) acc++;
         if (sb_ack0) begin lat = i; break; end
      end
      sb_req = 1'b0;
      if (lat !== 5) $display("FAIL w3_latency: got %0d expected 5", lat);
      else n_pass++;
      n_total++;
      if (acc !== 4) $display("FAIL w3_access_len: got %0d expected 4", acc);
      else n_pass++;
      n_total++;
      if (sb_rd0 !== 16'h00C3) $display("FAIL w3_rdata: got %h expected 00c3", sb_rd0);
      else n_pass++;
      n_total++;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_readback();
      test_byte_enable();
      test_contention();
      test_reset_mid_write();
      test_param_sweep();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Two-port arbiter and access sequencer for the board's asynchronous 16-bit SRAM, which has active-low CE/OE/WE/LB/UB, a 20-bit address and a bidirectional DQ bus.
- Port 0 is the CPU memory interface; port 1 is a secondary master such as the video/DMA engine.
- Grants one requester at a time using round-robin, holds the SRAM control signals for a fixed access window, and captures read data.
- Returns a single-cycle acknowledge to the granted port.
- Sole driver of the SRAM pins; sits between the requesters and the SRAM (or its simulation model).

Parameters:
WaitCycles, 1, extra cycles the SRAM controls are held beyond the first access cycle (0..15)

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
Req0, Req1  input  1  access request; must be held, with its fields stable, until the matching Ack
Wr0, Wr1  input  1  1 = write, 0 = read
Addr0, Addr1  input  20  word address
WData0, WData1  input  16  write data
BE0, BE1  input  2  byte enables, active-high; [1] = upper byte, [0] = lower byte
Ack0, Ack1  output  1  one-cycle completion pulse
RData0, RData1  output  16  read data; valid in the Ack cycle and held until that port's next read completes
Busy  output  1  high whenever state is not IDLE
CE, OE, WE, LB, UB  output  1  SRAM controls, active-low
ADDR  output  20  SRAM address
DQ  inout  16  SRAM data bus

Behaviour:
- Reset values:
  - State IDLE.
  - CE, OE, WE, LB, UB = 1; ADDR = 0; DQ = Z.
  - Ack0 and Ack1 = 0; RData0 and RData1 = 0; Busy = 0.
  - Round-robin pointer Last = 1, so port 0 wins the first tie.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Requests are sampled only in this state.
  - If exactly one Req is high, that port is granted.
  - If both are high, the port != Last is granted.
  - On grant, register Wr/Addr/WData/BE of the granted port, set Last to the granted port, load Cnt = WaitCycles, and go to ACCESS.
  - If neither Req is high, remain in IDLE.
- ACCESS:
  - Lasts exactly WaitCycles+1 cycles.
  - CE = 0; ADDR = registered address; UB = ~BE[1]; LB = ~BE[0].
  - Read: OE = 0, WE = 1, DQ = Z.
  - Write: OE = 1, WE = 0, DQ driven with registered WData for the whole state.
  - Cnt decrements each cycle. On the edge where Cnt == 0, go to DONE; for a read, DQ is captured into the granted port's RData on that same edge.
  - On capture, disabled byte lanes are stored as 0x00, never Z/X.
- DONE:
  - Exactly one cycle.
  - All SRAM controls deasserted (=1); DQ = Z, which gives one bus-turnaround cycle.
  - Ack of the granted port = 1; the other Ack = 0.
  - Next state IDLE.
- Latency: with Req sampled at edge k, Ack is high in the cycle after edge k+WaitCycles+1.
  - Minimum request-to-request spacing is WaitCycles+3 cycles.
- Re-request: Req still high in IDLE after its Ack is treated as a new access.
  - Under contention, round-robin guarantees the other port is served before a repeat.
- BE = 00: the cycle completes normally with LB = UB = 1 and no byte written; a read returns 0x0000.
- Address range is not checked; all 20 bits are passed through.
- Reset mid-operation: the access is abandoned, no Ack is issued, and all outputs return to their reset values on the next edge. The SRAM contents for an in-progress write are undefined.
- DQ is never driven by this block while OE = 0, and never driven outside ACCESS.

Test Plan:
- Reset, then a single read: port 0 reads Addr = 0x00001 with BE = 11 and the SRAM holding 0x102F (WaitCycles = 1) -> CE = OE = 0 for 2 cycles, WE = 1, DQ released; Ack0 pulses 3 cycles after Req0 is sampled; RData0 = 0x102F.
- Write then read-back: port 1 writes 0xBEEF to 0x00005 with BE = 11, then reads 0x00005 -> WE = 0 for 2 cycles with DQ = 0xBEEF; Ack1 pulses; the read returns RData1 = 0xBEEF.
- Byte enable: write 0x1234 with BE = 01 to a word holding 0xBEEF, then read with BE = 11 -> 0xBE34. A read with BE = 10 of the same word -> 0xBE00.
- Contention: Req0 and Req1 both held continuously after reset -> grant order is 0, 1, 0, 1; each Ack is exactly one cycle; Busy is low for exactly one cycle between accesses.
- Reset mid-write: assert Reset during the first ACCESS cycle -> next edge gives CE = WE = 1, DQ = Z, no Ack; after reset, port 0 wins a tie.
- Parameter sweep: WaitCycles = 0 and 3 -> ACCESS lengths of 1 and 4 cycles; Ack at +2 and +5 cycles respectively; read data is correct in both cases.
